uart_tx_feeder: RTL and testbench



---
 rtl/uart_tx_feeder_pkg.sv | 20 ++
 rtl/uart_tx_feeder_fifo.sv | 72 +++++++
 rtl/uart_tx_feeder.sv | 100 ++++++++++
 tb/tb_uart_tx_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types for the UART transmit feeder (byte type and the
//                launch FSM state encoding).
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_feeder_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_fifo
//  Description : Synchronous byte FIFO with a combinationally visible head,
//                full/empty flags and an occupancy count. A push while full is
//                refused even if a pop happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  byte_t         data_i,
    output byte_t         head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);

    byte_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q,  level_d;
    logic           w_do_push;
    logic           w_do_pop;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (w_do_push && !w_do_pop)      level_d = level_q + 1'b1;
        else if (!w_do_push && w_do_pop) level_d = level_q - 1'b1;
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_feeder
//  Description : Buffers bytes from a valid/ready producer and launches them
//                one at a time into an 8-bit UART transmitter, pacing on the
//                transmitter's busy/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          tx_en,
    input  logic          tx_busy,
    input  logic          tx_done,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic          idle
);

    feeder_state_t  state_q, state_d;
    byte_t          tx_data_q, tx_data_d;
    logic           overflow_q, overflow_d;

    byte_t          w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_pop;

    assign w_pop = (state_q == S_LAUNCH);

    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_valid),
        .pop_i   (w_pop),
        .data_i  (wr_data),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level)
    );

    // Launch FSM next-state; tx_data is captured on the edge entering
    // S_LAUNCH so it is already valid while tx_start is high.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        overflow_d = overflow_q | (wr_valid && w_full);
        case (state_q)
            S_IDLE: begin
                // Guard on the transmitter itself so a byte still in flight
                // after a reset is never overlapped.
                if (!w_empty && enable && tx_done && !tx_busy) begin
                    state_d   = S_LAUNCH;
                    tx_data_d = w_head;
                end
            end
            S_LAUNCH:    state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (tx_done && !tx_busy) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State, launch data and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_ready = !w_full;
    assign tx_start = (state_q == S_LAUNCH);
    assign tx_data  = tx_data_q;
    assign tx_en    = enable;
    assign overflow = overflow_q;
    assign idle     = w_empty && (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_feeder
//  Description : Self-checking bench for uart_tx_feeder with a behavioural
//                18-cycle UART transmitter and a launch scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_busy;
    logic       tx_done;
    logic [4:0] level;
    logic       overflow;
    logic       idle;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         n_starts   = 0;
    int         cyc        = 0;
    int         last_start = -1;
    bit         chk_gap    = 1'b0;
    bit         prev_start = 1'b0;
    logic [10:0] frame     = '0;

    // Transmitter model: 18 busy cycles per byte, no reset.
    logic       m_busy = 1'b0;
    int         m_cnt  = 0;
    logic [7:0] m_sh   = '0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(16), .LW(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .level    (level),
        .overflow (overflow),
        .idle     (idle)
    );

    assign tx_busy = m_busy;
    assign tx_done = !m_busy;

    always @(posedge clk) begin
        if (m_busy) begin
            if (m_cnt == 1) m_busy <= 1'b0;
            m_cnt <= m_cnt - 1;
        end else if (tx_start && tx_en) begin
            m_busy <= 1'b1;
            m_cnt  <= 18;
            m_sh   <= tx_data;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard of launched bytes, pulse width, overlap and spacing.
    always @(negedge clk) begin
        int   ph;
        logic b;
        cyc++;
        if (tx_start === 1'b1) begin
            n_starts++;
            if (prev_start) check("start_single_cycle", 32'd1, 32'd0);
            check("start_while_busy", {31'd0, tx_busy}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_start: got tx_data %0h expected no launch", tx_data);
            end else begin
                check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            if (chk_gap && last_start >= 0)
                check("start_spacing", cyc - last_start, 32'd21);
            last_start = cyc;
        end
        prev_start = (tx_start === 1'b1);
        if (m_busy) begin
            ph = 18 - m_cnt;
            b  = (ph == 0) ? 1'b0 : (ph <= 8) ? m_sh[ph-1] : 1'b1;
            if (ph <= 9)       frame[ph] = b;
            else if (ph == 17) frame[10] = b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit acc);
        wr_valid = 1'b1;
        wr_data  = d;
        check("wr_ready", {31'd0, wr_ready}, {31'd0, acc});
        if (acc) exp_q.push_back(d);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (idle === 1'b1 && !m_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(nm, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         n0;
        logic [10:0] exp_frame;
        exp_frame = 11'b11101001010;
        reset    = 1'b1;
        enable   = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data",  {24'd0, tx_data},  32'd0);
        check("rst_level",    {27'd0, level},    32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_idle",     {31'd0, idle},     32'd1);
        check("rst_tx_en",    {31'd0, tx_en},    32'd1);

        // Single byte and minimum latency
        push(8'hA5, 1'b1);
        check("lat_level_k", {27'd0, level},    32'd1);
        check("lat_start_k", {31'd0, tx_start}, 32'd0);
        tick();
        check("lat_start_k1", {31'd0, tx_start}, 32'd1);
        wait_idle(60, "single_drain");
        check("single_level", {27'd0, level}, 32'd0);
        check("serial_frame", {21'd0, frame}, {21'd0, exp_frame});

        // Burst of 16 consecutive pushes
        last_start = -1;
        chk_gap    = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
        check("burst_level_peak", {27'd0, level}, 32'd15);
        wait_idle(400, "burst_drain");
        chk_gap = 1'b0;

        // Overflow with launches held off
        enable = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b1);
        check("full_level",    {27'd0, level},    32'd16);
        check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        push(8'hFF, 1'b0);
        check("overflow_set", {31'd0, overflow}, 32'd1);
        check("full_level_after", {27'd0, level}, 32'd16);
        n0 = n_starts;
        enable = 1'b1;
        wait_idle(16 * 21 + 60, "ovf_drain");
        check("ovf_sent_count", n_starts - n0, 32'd16);

        // Simultaneous push and pop at level 3
        enable = 1'b0;
        tick();
        push(8'h30, 1'b1);
        push(8'h31, 1'b1);
        push(8'h32, 1'b1);
        check("pp_level_before", {27'd0, level}, 32'd3);
        enable = 1'b1;
        tick();
        check("pp_launch", {31'd0, tx_start}, 32'd1);
        check("pp_level_launch", {27'd0, level}, 32'd3);
        wr_valid = 1'b1;
        wr_data  = 8'h33;
        exp_q.push_back(8'h33);
        tick();
        wr_valid = 1'b0;
        check("pp_level_after", {27'd0, level}, 32'd3);
        wait_idle(4 * 21 + 60, "pp_drain");

        // Enable gating mid-byte
        push(8'h3C, 1'b1);
        push(8'h3D, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (tx_start === 1'b1) break;
            tick();
        end
        repeat (5) tick();
        enable = 1'b0;
        n0 = n_starts;
        repeat (60) tick();
        check("gate_no_launch", n_starts - n0, 32'd0);
        check("gate_level",     {27'd0, level},   32'd1);
        check("gate_completed", {31'd0, tx_busy}, 32'd0);
        check("gate_tx_en",     {31'd0, tx_en},   32'd0);
        enable = 1'b1;
        wait_idle(80, "gate_drain");
        check("gate_resume", n_starts - n0, 32'd1);

        // Reset during the first stop field with 5 bytes queued
        for (int i = 0; i < 6; i++) push(8'h40 + 8'(i), 1'b1);
        repeat (8) tick();
        check("mid_busy",     {31'd0, tx_busy},  32'd1);
        check("mid_level",    {27'd0, level},    32'd5);
        check("mid_overflow", {31'd0, overflow}, 32'd1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        check("mrst_level",    {27'd0, level},    32'd0);
        check("mrst_overflow", {31'd0, overflow}, 32'd0);
        check("mrst_idle",     {31'd0, idle},     32'd1);
        check("mrst_tx_data",  {24'd0, tx_data},  32'd0);
        check("mrst_tx_busy",  {31'd0, tx_busy},  32'd1);
        n0 = n_starts;
        push(8'h50, 1'b1);
        wait_idle(80, "mrst_drain");
        check("mrst_one_launch", n_starts - n0, 32'd1);

        tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
